// File: rtl/data_collector_pkg.sv
// data_collector_pkg
//   Shared definitions for the data collector slice: default bus geometry,
//   FSM state encoding and a saturating counter helper.
//   Optional statistics are enabled with the macro DATA_COLLECTOR_STATS_EN.
package data_collector_pkg;

  localparam int DEF_DATA_WIDTH               = 4;
  localparam int DEF_SELECTOR_OUTPUTS         = 4;
  localparam int DEF_SELECTOR_OUTPUTS_PER_BUS = 4;
  localparam int DEF_FIFO_DEPTH               = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // 16-bit add of a small increment, clamping at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/data_collector_if.sv
// data_collector_if
//   Groups the scheduler beat stream (data_in/data_valid/data_sof) and the
//   parallel frame output handshake (out_data/out_valid/out_ready).
//   Modports:
//     slave  - the collector: consumes beats, produces frames
//     master - the environment: produces beats, consumes frames
interface data_collector_if #(
  parameter int W       = 16,
  parameter int FRAME_W = 64
);
  logic [W-1:0]       data_in;
  logic               data_valid;
  logic               data_sof;
  logic [FRAME_W-1:0] out_data;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  data_in, data_valid, data_sof, out_ready,
    output out_data, out_valid
  );

  modport master (
    output data_in, data_valid, data_sof, out_ready,
    input  out_data, out_valid
  );
endinterface

// File: rtl/data_collector_frame_fifo.sv
// frame_fifo
//   Synchronous FIFO of complete frames, power-of-two DEPTH.
//   Ports: clk, rst (async, active-high), push/push_data, pop, head_data
//   (head entry, 0 when empty), full, empty, count_next (occupancy after
//   this cycle's push/pop). A push into a full FIFO is accepted only when a
//   pop happens in the same cycle; otherwise it is ignored.
module frame_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count_next
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok, pop_ok;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CW'(DEPTH));
  assign pop_ok     = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push && (!full || pop_ok);
  assign count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
  // Head is read asynchronously so a frame is visible the cycle after it lands.
  assign head_data  = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end
endmodule

// File: rtl/data_collector.sv
// data_collector
//   Reassembles round-robin scheduler beats (slot 0..SELECTOR_OUTPUTS-1) into
//   frames, buffers them in frame_fifo and presents each frame in parallel.
//   Ports: clk, rst (async, active-high), bus (data_collector_if.slave:
//   beat stream in, frame handshake out), wBusy (FIFO nearly full),
//   overflow (sticky frame drop), resync (sticky mid-frame sof).
//   Optional macro DATA_COLLECTOR_STATS_EN adds frame_count/drop_count.
//   Assumes SELECTOR_OUTPUTS >= 2.
module data_collector
  import data_collector_pkg::*;
#(
  parameter int DATA_WIDTH               = DEF_DATA_WIDTH,
  parameter int SELECTOR_OUTPUTS         = DEF_SELECTOR_OUTPUTS,
  parameter int SELECTOR_OUTPUTS_PER_BUS = DEF_SELECTOR_OUTPUTS_PER_BUS,
  parameter int FIFO_DEPTH               = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  data_collector_if.slave bus,
  output logic            wBusy,
  output logic            overflow,
  output logic            resync
`ifdef DATA_COLLECTOR_STATS_EN
  ,
  output logic [15:0]     frame_count,
  output logic [15:0]     drop_count
`endif
);
  localparam int W       = DATA_WIDTH * SELECTOR_OUTPUTS_PER_BUS;
  localparam int FRAME_W = W * SELECTOR_OUTPUTS;
  localparam int SLOT_W  = (SELECTOR_OUTPUTS > 1) ? $clog2(SELECTOR_OUTPUTS) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SELECTOR_OUTPUTS - 1);

  state_t              state_reg, state_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next, store_slot;
  logic                store_en, done_next, resync_hit;
  logic                frame_done_reg, busy_reg, overflow_reg, resync_reg;
  logic [FRAME_W-1:0]  frame_flat;
  logic                fifo_full, fifo_empty, pop, drop_frame;
  logic [CNT_W-1:0]    fifo_count_next;

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    store_en   = 1'b0;
    store_slot = slot_reg;
    done_next  = 1'b0;
    resync_hit = 1'b0;
    if (bus.data_valid) begin
      case (state_reg)
        IDLE: begin
          if (bus.data_sof) begin
            store_en   = 1'b1;
            store_slot = '0;
            slot_next  = SLOT_W'(1);
            state_next = COLLECT;
          end
        end
        COLLECT: begin
          store_en = 1'b1;
          if (bus.data_sof) begin
            // Restart: partial frame is abandoned, this beat becomes slot 0.
            resync_hit = 1'b1;
            store_slot = '0;
            slot_next  = SLOT_W'(1);
          end else if (slot_reg == LAST_SLOT) begin
            done_next  = 1'b1;
            slot_next  = '0;
            state_next = IDLE;
          end else begin
            slot_next = slot_reg + SLOT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SELECTOR_OUTPUTS; gi++) begin : g_slot
      logic [W-1:0] stage_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          stage_reg <= '0;
        else if (store_en && store_slot == SLOT_W'(gi))
          stage_reg <= bus.data_in;
      end
      assign frame_flat[gi*W +: W] = stage_reg;
    end
  endgenerate

  // frame_done_reg pushes the staged frame one edge after its last beat;
  // a new slot 0 written on that same edge does not disturb the push data.
  frame_fifo #(.WIDTH(FRAME_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (frame_done_reg),
    .push_data  (frame_flat),
    .pop        (pop),
    .head_data  (bus.out_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count_next (fifo_count_next)
  );

  assign bus.out_valid = !fifo_empty;
  assign pop           = bus.out_valid && bus.out_ready;
  assign drop_frame    = frame_done_reg && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      slot_reg       <= '0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      resync_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      frame_done_reg <= done_next;
      // Built from next-state occupancy so wBusy tracks the FIFO without lag.
      busy_reg       <= (fifo_count_next >= CNT_W'(FIFO_DEPTH - 1));
      if (drop_frame) overflow_reg <= 1'b1;
      if (resync_hit) resync_reg   <= 1'b1;
    end
  end

  assign wBusy    = busy_reg;
  assign overflow = overflow_reg;
  assign resync   = resync_reg;

`ifdef DATA_COLLECTOR_STATS_EN
  logic [15:0] frame_count_reg, drop_count_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count_reg <= '0;
      drop_count_reg  <= '0;
    end else begin
      frame_count_reg <= sat_add16(frame_count_reg, {1'b0, pop});
      drop_count_reg  <= sat_add16(drop_count_reg, {1'b0, drop_frame} + {1'b0, resync_hit});
    end
  end
  assign frame_count = frame_count_reg;
  assign drop_count  = drop_count_reg;
`endif
endmodule
